// File: rtl/reservation_station.sv
// reservation_station: operand-capturing reservation station for one functional unit.
// Ports: clk/rst (sync, active-high), flush; common_data_bus_i (CDB snoop lanes);
//   vld_i/rdy_i/instruction_i (dispatch in); vld_o/rdy_o/instruction_o (issue out).
// Build option: define RS_OLDEST_FIRST_EN to select the oldest ready entry instead of
//   the lowest-index ready entry.

package rs_pkg;
  localparam int ROB_IDX_LEN    = 4;
  localparam int NUM_CDB_INPUTS = 2;

  // CBx=1: valx[ROB_IDX_LEN-1:0] holds the pending ROB tag; CBx=0: valx is the operand.
  typedef struct packed {
    logic [5:0]             opcode;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
    logic                   CB1;
    logic [31:0]            val1;
    logic                   CB2;
    logic [31:0]            val2;
  } instruction_element_t;

  typedef struct packed {
    logic                   valid;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
    logic [31:0]            data;
  } cdb_lane_t;

  typedef cdb_lane_t [NUM_CDB_INPUTS-1:0] common_data_bus_t;
endpackage

// Purpose: hold dispatched entries until both operands resolve via CDB snoop, issue one per cycle.
// Latency: accepted ready entry visible on vld_o the next cycle; CDB capture issuable the cycle after.
// Backpressure: rdy_i drops when every entry is busy (independent of rdy_o); issue holds while !rdy_o.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ROB_IDX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  common_data_bus_t     common_data_bus_i,
  input  logic                 vld_i,
  output logic                 rdy_i,
  input  instruction_element_t instruction_i,
  output logic                 vld_o,
  input  logic                 rdy_o,
  output instruction_element_t instruction_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry state
  logic [DEPTH-1:0]     busy_q, busy_d;
  instruction_element_t ent_q [DEPTH];
  instruction_element_t ent_d [DEPTH];

`ifdef RS_OLDEST_FIRST_EN
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] age_d [DEPTH];
`endif

  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             full;
  logic             accept;
  logic             issue;

  // Capture CDB results into a waiting operand. Lanes are scanned in ascending order and
  // each match overwrites the previous one, so the highest matching lane wins. The
  // original CBx is tested so an earlier capture does not hide a later lane.
  function automatic instruction_element_t snoop(input instruction_element_t ins,
                                                 input common_data_bus_t     cdb);
    instruction_element_t r;
    r = ins;
    for (int l = 0; l < NUM_CDB_INPUTS; l++) begin
      if (cdb[l].valid && ins.CB1 &&
          (ins.val1[TAG_W-1:0] == TAG_W'(cdb[l].ROB_dest))) begin
        r.val1 = cdb[l].data;
        r.CB1  = 1'b0;
      end
      if (cdb[l].valid && ins.CB2 &&
          (ins.val2[TAG_W-1:0] == TAG_W'(cdb[l].ROB_dest))) begin
        r.val2 = cdb[l].data;
        r.CB2  = 1'b0;
      end
    end
    return r;
  endfunction

  // Readiness looks at registered state only: a same-cycle CDB capture never bypasses to issue.
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && !ent_q[i].CB1 && !ent_q[i].CB2;
    end
  end

  // Issue selection
`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] best_age;
    sel_idx  = '0;
    found    = 1'b0;
    best_age = '0;
    // Strict '>' keeps the lower index on an age tie.
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || (age_q[i] > best_age))) begin
        sel_idx  = IDX_W'(i);
        best_age = age_q[i];
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end
`endif

  // Lowest free entry for the incoming dispatch
  always_comb begin
    logic found;
    free_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !found) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign full  = &busy_q;
  // An entry freed by this cycle's issue is not reusable until next cycle, which keeps
  // rdy_i free of any path from rdy_o.
  assign rdy_i = !rst && !flush && !full;
  assign vld_o = |ready;

  assign accept = vld_i && rdy_i;
  assign issue  = vld_o && rdy_o;

  always_comb begin
    instruction_o = '0;
    if (vld_o) begin
      instruction_o = ent_q[sel_idx];
    end
  end

  // Next state: snoop stored entries, retire the issued one, write the accepted one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (busy_q[i]) begin
        ent_d[i] = snoop(ent_q[i], common_data_bus_i);
      end
    end
    if (issue) begin
      busy_d[sel_idx] = 1'b0;
    end
    if (accept) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = snoop(instruction_i, common_data_bus_i);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Ages count accepts seen since the entry arrived, saturating at DEPTH-1.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (accept && busy_q[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
    if (accept) begin
      age_d[free_idx] = '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Payload and age are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      ent_q <= ent_d;
`ifdef RS_OLDEST_FIRST_EN
      age_q <= age_d;
`endif
    end
  end

endmodule
